// File: rtl/aging_vec_player.sv
// Stimulus-vector player: replays a loaded vector table into a DUT, folds each
// settled response into a MISR signature, and compares it against a golden value.
module aging_vec_player #(
  parameter int unsigned      IN_W       = 32,
  parameter int unsigned      OUT_W      = 32,
  parameter int unsigned      DEPTH      = 64,
  parameter int unsigned      SETTLE_CYC = 1,
  parameter logic [OUT_W-1:0] MISR_POLY  = OUT_W'(32'h0000_00C5),
  localparam int unsigned     AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [IN_W-1:0]  load_data,
  input  logic [AW:0]      cfg_len,
  input  logic [15:0]      cfg_loops,
  input  logic             start,
  input  logic             stop,
  input  logic [OUT_W-1:0] golden_sig,
  input  logic [OUT_W-1:0] dut_out,
  output logic [IN_W-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             sig_match,
  output logic [OUT_W-1:0] misr_sig,
  output logic [AW-1:0]    vec_idx,
  output logic [15:0]      pass_cnt
);

  localparam int unsigned WCW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [WCW-1:0] WAIT_INIT = WCW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [IN_W-1:0]  mem [DEPTH];
  logic [IN_W-1:0]  dut_in_q;
  logic [OUT_W-1:0] misr_q, misr_d;
  logic [AW-1:0]    vec_idx_q;
  logic [15:0]      pass_cnt_q, pass_inc, pass_sat;
  logic [AW:0]      len_q;
  logic [15:0]      loops_q;
  logic [WCW-1:0]   wait_q;
  logic             busy_q, done_q, aborted_q, sig_match_q;
  logic             len_ok, last_vec;

  assign len_ok   = (cfg_len != '0) && (cfg_len <= DEPTH_L);
  assign last_vec = ({1'b0, vec_idx_q} == (len_q - (AW+1)'(1)));
  assign pass_inc = pass_cnt_q + 16'd1;
  assign pass_sat = (pass_cnt_q == '1) ? '1 : pass_inc;

  always_comb begin
    misr_d = (misr_q << 1) ^ dut_out ^ (misr_q[OUT_W-1] ? MISR_POLY : '0);
  end

  // Table is writable only between runs; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (load_en && (state_q == S_IDLE) && ({1'b0, load_addr} < DEPTH_L)) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dut_in_q    <= '0;
      misr_q      <= '0;
      vec_idx_q   <= '0;
      pass_cnt_q  <= '0;
      len_q       <= '0;
      loops_q     <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      sig_match_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && len_ok) begin
            len_q       <= cfg_len;
            loops_q     <= cfg_loops;
            misr_q      <= '0;
            vec_idx_q   <= '0;
            pass_cnt_q  <= '0;
            aborted_q   <= 1'b0;
            sig_match_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (stop) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            dut_in_q <= mem[vec_idx_q];
            wait_q   <= WAIT_INIT;
            state_q  <= (SETTLE_CYC > 0) ? S_WAIT : S_CAPTURE;
          end
        end
        S_WAIT: begin
          if (stop) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end else if (wait_q == '0) begin
            state_q <= S_CAPTURE;
          end else begin
            wait_q <= wait_q - WCW'(1);
          end
        end
        S_CAPTURE: begin
          // Abort wins over the capture in the same cycle: signature is frozen.
          if (stop) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            misr_q <= misr_d;
            if (!last_vec) begin
              vec_idx_q <= vec_idx_q + AW'(1);
              state_q   <= S_APPLY;
            end else begin
              pass_cnt_q <= pass_sat;
              if ((loops_q != '0) && (pass_inc == loops_q)) begin
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end else begin
                vec_idx_q <= '0;
                state_q   <= S_APPLY;
              end
            end
          end
        end
        S_DONE: begin
          done_q      <= 1'b1;
          sig_match_q <= (misr_q == golden_sig) && !aborted_q;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign sig_match = sig_match_q;
  assign misr_sig  = misr_q;
  assign vec_idx   = vec_idx_q;
  assign pass_cnt  = pass_cnt_q;

endmodule

// File: doc/aging_vec_player.md
AGING_VEC_PLAYER -- requirements
Module: aging_vec_player

Interface
REQ-001 SHALL have parameter IN_W, default 32, width of stimulus vector driven to the DUT.
REQ-002 SHALL have parameter OUT_W, default 32, width of DUT response sampled.
REQ-003 SHALL have parameter DEPTH, default 64, number of stimulus memory entries; AW = clog2(DEPTH), derived.
REQ-004 SHALL have parameter SETTLE_CYC, default 1, wait cycles between applying a vector and capturing the response (0 legal).
REQ-005 SHALL have parameter MISR_POLY, default 32'h0000_00C5 truncated to OUT_W, feedback taps of the signature register.
REQ-006 One clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 load_en  in  1  write strobe for stimulus memory.
REQ-009 load_addr  in  AW  stimulus memory write address.
REQ-010 load_data  in  IN_W  stimulus memory write data.
REQ-011 cfg_len  in  AW+1  vectors per pass, legal 1..DEPTH.
REQ-012 cfg_loops  in  16  passes to run; 0 = run until stop.
REQ-013 start  in  1  single-cycle run request.
REQ-014 stop  in  1  abort request.
REQ-015 golden_sig  in  OUT_W  expected final signature.
REQ-016 dut_out  in  OUT_W  DUT response.
REQ-017 dut_in  out  IN_W  registered stimulus to DUT.
REQ-018 busy  out  1  run in progress.
REQ-019 done  out  1  one-cycle end-of-run pulse.
REQ-020 aborted  out  1  last run ended by stop.
REQ-021 sig_match  out  1  last run's signature equals golden_sig.
REQ-022 misr_sig  out  OUT_W  current signature.
REQ-023 vec_idx  out  AW  index of vector currently applied.
REQ-024 pass_cnt  out  16  completed passes in current/last run.

Function
REQ-025 Memory write SHALL occur on load_en only while IDLE; load_en while busy SHALL be ignored; load_addr >= DEPTH ignored.
REQ-026 FSM states SHALL be IDLE, APPLY, WAIT, CAPTURE, DONE; busy = 1 in APPLY, WAIT, CAPTURE.
REQ-027 IDLE: start with 1 <= cfg_len <= DEPTH SHALL latch cfg_len/cfg_loops, clear misr_sig, vec_idx, pass_cnt, aborted, sig_match, go to APPLY; illegal cfg_len SHALL leave FSM in IDLE.
REQ-028 start while not IDLE SHALL be ignored; cfg changes mid-run SHALL not affect the run.
REQ-029 APPLY (1 cycle): dut_in <= mem[vec_idx]; next WAIT if SETTLE_CYC > 0, else CAPTURE.
REQ-030 WAIT SHALL last exactly SETTLE_CYC cycles, then CAPTURE.
REQ-031 CAPTURE (1 cycle): misr_sig <= (misr_sig << 1) XOR (misr_sig[OUT_W-1] ? MISR_POLY : 0) XOR dut_out.
REQ-032 In CAPTURE, if vec_idx < len-1: vec_idx+1, APPLY; else pass_cnt+1 and, if loops != 0 and pass_cnt+1 == loops, DONE, otherwise vec_idx = 0, APPLY.
REQ-033 Per-vector latency SHALL be SETTLE_CYC+2 cycles; a run SHALL assert done exactly len*loops*(SETTLE_CYC+2)+1 cycles after the cycle start is sampled.
REQ-034 pass_cnt SHALL saturate at 16'hFFFF in continuous mode; signature keeps accumulating across passes.
REQ-035 stop in APPLY/WAIT/CAPTURE SHALL go to DONE next cycle with no further MISR update, aborted = 1; stop has priority over CAPTURE progress in the same cycle; stop in IDLE/DONE ignored.
REQ-036 DONE (1 cycle): done = 1, sig_match <= (misr_sig == golden_sig) and not aborted, then IDLE.
REQ-037 dut_in, misr_sig, sig_match, aborted, pass_cnt, vec_idx SHALL hold after DONE until next accepted start (dut_in holds until next APPLY).

Reset
REQ-038 rst_n low SHALL force IDLE and all outputs to 0 (dut_in, busy, done, aborted, sig_match, misr_sig, vec_idx, pass_cnt) asynchronously, including mid-run.
REQ-039 Stimulus memory contents SHALL not require reset; bench reloads after reset.

Verification
REQ-040 IN_W=OUT_W=8, DEPTH=4, SETTLE_CYC=1, POLY=8'h1D, dut_out looped from dut_in, mem={80,01}, len=2, loops=1, golden=1C -> misr_sig 80 then 1C, done 7 cycles after start, sig_match=1.
REQ-041 Same, loops=3 -> pass_cnt=3, done 19 cycles after start, vec_idx sequence 0,1,0,1,0,1.
REQ-042 loops=0, stop after 10 cycles -> done next cycle, aborted=1, sig_match=0, busy=0.
REQ-043 cfg_len=0 or 5 with start -> busy stays 0, no done; load_en while busy -> memory unchanged on next run.
REQ-044 rst_n low during WAIT -> all outputs 0 immediately, next start runs cleanly from vec_idx 0.
REQ-045 SETTLE_CYC=0, len=4, loops=1 -> done 9 cycles after start, one MISR update every 2 cycles.
